// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares a single combinational ALU between two requesting ports.
//   Requests are arbitrated round-robin. The winner's result is captured in
//   a shared result register and held for the winning (owner) port until
//   that port accepts it. A new request may be accepted in the same cycle the
//   held result is consumed, which gives one operation per cycle.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-port request valid (port 0 = bit 0)
//   req_ready  : per-port request accept (one-hot or zero)
//   req_sel0/1 : ALU operation code per port (ALU_* macros below)
//   req_a0/b0  : port 0 operands
//   req_a1/b1  : port 1 operands
//   rsp_valid  : per-port result valid (never both high)
//   rsp_ready  : per-port result accept
//   rsp_data   : shared result register
// ---------------------------------------------------------------------------

`ifndef ALU_ARBITER_OPS
`define ALU_ARBITER_OPS
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`endif

// ---------------------------------------------------------------------------
// alu
//   Purely combinational ALU. Shift amount is taken from the low bits of b.
//   Any encoding not listed produces zero.
//
// Ports
//   sel    : operation code
//   a, b   : operands
//   result : operation result
// ---------------------------------------------------------------------------
module alu #(
  parameter int DATAW = 32
) (
  input  logic [3:0]       sel,
  input  logic [DATAW-1:0] a,
  input  logic [DATAW-1:0] b,
  output logic [DATAW-1:0] result
);

  localparam int SHW = $clog2(DATAW);

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  // Operation decode; unknown codes fall through to zero
  always_comb begin
    result = '0;
    case (sel)
      `ALU_ADD:  result = a + b;
      `ALU_SUB:  result = a - b;
      `ALU_SLL:  result = a << shamt;
      `ALU_SLT:  result = {{(DATAW-1){1'b0}}, ($signed(a) < $signed(b))};
      `ALU_SLTU: result = {{(DATAW-1){1'b0}}, (a < b)};
      `ALU_XOR:  result = a ^ b;
      `ALU_SRL:  result = a >> shamt;
      `ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      `ALU_OR:   result = a | b;
      `ALU_AND:  result = a & b;
      default:   result = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_sel0,
  input  logic [3:0]       req_sel1,
  input  logic [DATAW-1:0] req_a0,
  input  logic [DATAW-1:0] req_b0,
  input  logic [DATAW-1:0] req_a1,
  input  logic [DATAW-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [DATAW-1:0] rsp_data
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             owner;
  logic             owner_next;
  logic             prio;
  logic             prio_next;
  logic             load;
  logic             rsp_fire;
  logic             slot_free;
  logic [3:0]       alu_sel;
  logic [DATAW-1:0] alu_a;
  logic [DATAW-1:0] alu_b;
  logic [DATAW-1:0] alu_result;

  // The held result is only visible on the owner's lane
  assign rsp_valid = (state == HOLD) ? (owner ? 2'b10 : 2'b01) : 2'b00;

  // Operands come from the granted port; port 0 when nobody is granted
  assign alu_sel = req_ready[1] ? req_sel1 : req_sel0;
  assign alu_a   = req_ready[1] ? req_a1   : req_a0;
  assign alu_b   = req_ready[1] ? req_b1   : req_b0;

  alu #(.DATAW(DATAW)) u_alu (
    .sel    (alu_sel),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result)
  );

  // Arbitration and next-state logic. The slot frees up either when nothing
  // is held or when the owner consumes its result this very cycle, so a new
  // grant can overlap the outgoing response. rst_n gates req_ready so no
  // request appears accepted while reset is held.
  always_comb begin
    req_ready  = 2'b00;
    state_next = state;
    owner_next = owner;
    prio_next  = prio;
    load       = 1'b0;
    rsp_fire   = (state == HOLD) && rsp_ready[owner];
    slot_free  = (state == IDLE) || rsp_fire;

    if (rst_n && slot_free) begin
      if (req_valid == 2'b11) begin
        req_ready = prio ? 2'b10 : 2'b01;
      end else begin
        req_ready = req_valid;
      end
    end

    if (req_ready != 2'b00) begin
      state_next = HOLD;
      owner_next = req_ready[1];
      prio_next  = ~req_ready[1];
      load       = 1'b1;
    end else if (rsp_fire) begin
      state_next = IDLE;
    end
  end

  // State, ownership, priority pointer and result register. The result is
  // only overwritten on an accept, so it keeps its last value once idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      prio     <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      prio  <= prio_next;
      if (load) begin
        rsp_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. Expected results are computed by a
//   reference ALU function and pushed into per-port queues when a request is
//   accepted, then popped and compared when the port consumes its response.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_sel0;
  logic [3:0]  req_sel1;
  logic [31:0] req_a0;
  logic [31:0] req_b0;
  logic [31:0] req_a1;
  logic [31:0] req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;

  int checks;
  int failures;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  logic [3:0]  drv_sel[2];
  logic [31:0] drv_a[2];
  logic [31:0] drv_b[2];

  alu_arbiter #(.DATAW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel0  (req_sel0),
    .req_sel1  (req_sel1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so a stuck run still ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference ALU, written independently of the design
  function automatic logic [31:0] alu_ref(input logic [3:0] s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    r = 32'd0;
    case (s)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a + (~b) + 32'd1;
      OP_SLL:  r = a << sh;
      OP_SLT:  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      OP_SLTU: r = {31'd0, (a < b)};
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> sh;
      OP_SRA: begin
        r = a;
        for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
      end
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Scoreboard pop; an empty queue yields X so the comparison fails
  function automatic logic [31:0] pop_exp(input int p);
    if (p == 0) begin
      if (exp_q0.size() == 0) return 32'hxxxxxxxx;
      return exp_q0.pop_front();
    end
    if (exp_q1.size() == 0) return 32'hxxxxxxxx;
    return exp_q1.pop_front();
  endfunction

  // Drive one request port and remember what was driven
  task automatic set_port(input int p, input logic v, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] b);
    drv_sel[p] = s;
    drv_a[p]   = a;
    drv_b[p]   = b;
    req_valid[p] = v;
    if (p == 0) begin
      req_sel0 = s; req_a0 = a; req_b0 = b;
    end else begin
      req_sel1 = s; req_a1 = a; req_b1 = b;
    end
  endtask

  // Push the model result for every request the DUT is accepting now
  task automatic sb_push_accepts();
    for (int p = 0; p < 2; p++) begin
      if (req_valid[p] && req_ready[p]) begin
        if (p == 0) exp_q0.push_back(alu_ref(drv_sel[0], drv_a[0], drv_b[0]));
        else        exp_q1.push_back(alu_ref(drv_sel[1], drv_a[1], drv_b[1]));
      end
    end
  endtask

  // Reset with idle inputs; returns on a falling edge with reset released
  task automatic do_reset();
    rst_n = 1'b0;
    set_port(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    set_port(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    rsp_ready = 2'b00;
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] rr;
    rst_n = 1'b0;
    set_port(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_port(1, 1'b1, OP_ADD, 32'd1, 32'd1);
    rsp_ready = 2'b11;
    @(negedge clk);
    #4;
    rr = req_ready;
    checks++;
    if (rr !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_req_ready: got %b expected 00", rr);
    end
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_rsp_valid: got %b expected 00", rsp_valid);
    end
    checks++;
    if (rsp_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_rsp_data: got %h expected 00000000", rsp_data);
    end
  endtask

  task automatic test_single();
    logic [31:0] e;
    do_reset();
    set_port(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    #4;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL single_req_ready: got %b expected 01", req_ready);
    end
    sb_push_accepts();
    @(negedge clk);
    set_port(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    #4;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'd12) begin
      failures++;
      $display("[TB] FAIL single_rsp: got valid=%b data=%h expected valid=01 data=0000000c",
               rsp_valid, rsp_data);
    end
    @(negedge clk);
    rsp_ready = 2'b01;
    #4;
    e = pop_exp(0);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== e) begin
      failures++;
      $display("[TB] FAIL single_rsp_fire: got valid=%b data=%h expected valid=01 data=%h",
               rsp_valid, rsp_data, e);
    end
    @(negedge clk);
    #4;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_data !== 32'd12) begin
      failures++;
      $display("[TB] FAIL single_idle: got valid=%b data=%h expected valid=00 data=0000000c",
               rsp_valid, rsp_data);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rr;
    logic [1:0]  exp_rv;
    logic [31:0] e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        set_port(0, 1'b1, OP_SUB, 32'd10, 32'd3);
        set_port(1, 1'b1, OP_XOR, 32'hF0, 32'h0F);
        rsp_ready = 2'b11;
      end
      #4;
      exp_rr = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_rv = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      checks++;
      if (req_ready !== exp_rr || rsp_valid !== exp_rv) begin
        failures++;
        $display("[TB] FAIL contention_cycle%0d: got ready=%b valid=%b expected ready=%b valid=%b",
                 k, req_ready, rsp_valid, exp_rr, exp_rv);
      end
      if (k > 0) begin
        e = pop_exp(exp_rv[1] ? 1 : 0);
        checks++;
        if (rsp_data !== e || rsp_data !== ((k % 2 == 1) ? 32'd7 : 32'hFF)) begin
          failures++;
          $display("[TB] FAIL contention_data%0d: got %h expected %h", k, rsp_data, e);
        end
      end
      sb_push_accepts();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    do_reset();
    set_port(1, 1'b1, OP_SRA, 32'h80000000, 32'd4);
    #4;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL bp_accept: got %b expected 10", req_ready);
    end
    sb_push_accepts();
    @(negedge clk);
    set_port(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    set_port(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #4;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'hF8000000 || req_ready !== 2'b00) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b data=%h ready=%b expected valid=10 data=f8000000 ready=00",
                 i, rsp_valid, rsp_data, req_ready);
      end
    end
    @(negedge clk);
    rsp_ready = 2'b11;
    #4;
    e = pop_exp(1);
    checks++;
    if (rsp_data !== e || req_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL bp_release: got data=%h ready=%b expected data=%h ready=01",
               rsp_data, req_ready, e);
    end
    sb_push_accepts();
    @(negedge clk);
    set_port(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    #4;
    e = pop_exp(0);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== e) begin
      failures++;
      $display("[TB] FAIL bp_next: got valid=%b data=%h expected valid=01 data=%h",
               rsp_valid, rsp_data, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    do_reset();
    set_port(0, 1'b1, OP_ADD, 32'd3, 32'd4);
    #4;
    sb_push_accepts();
    @(negedge clk);
    set_port(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    set_port(1, 1'b1, OP_SLTU, 32'd1, 32'd2);
    rsp_ready = 2'b01;
    #4;
    e = pop_exp(0);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== e || req_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL b2b_first: got valid=%b data=%h ready=%b expected valid=01 data=%h ready=10",
               rsp_valid, rsp_data, req_ready, e);
    end
    sb_push_accepts();
    @(negedge clk);
    set_port(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    rsp_ready = 2'b10;
    #4;
    e = pop_exp(1);
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== e || rsp_data !== 32'd1) begin
      failures++;
      $display("[TB] FAIL b2b_second: got valid=%b data=%h expected valid=10 data=%h",
               rsp_valid, rsp_data, e);
    end
    @(negedge clk);
    #4;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("[TB] FAIL b2b_idle: got %b expected 00", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] e;
    do_reset();
    set_port(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    #4;
    sb_push_accepts();
    @(negedge clk);
    set_port(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    #4;
    checks++;
    if (rsp_valid !== 2'b01) begin
      failures++;
      $display("[TB] FAIL midrst_hold: got %b expected 01", rsp_valid);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL midrst_async: got valid=%b data=%h expected valid=00 data=00000000",
               rsp_valid, rsp_data);
    end
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_port(1, 1'b1, OP_OR, 32'd3, 32'd4);
    #4;
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL midrst_release: got valid=%b ready=%b expected valid=00 ready=10",
               rsp_valid, req_ready);
    end
    sb_push_accepts();
    @(negedge clk);
    set_port(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    rsp_ready = 2'b11;
    #4;
    e = pop_exp(1);
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== e) begin
      failures++;
      $display("[TB] FAIL midrst_first_op: got valid=%b data=%h expected valid=10 data=%h",
               rsp_valid, rsp_data, e);
    end
  endtask

  task automatic test_random();
    logic        pend[2];
    int          waits[2];
    logic        hold_v[2];
    logic [31:0] hold_d;
    logic [31:0] e;
    int          q;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; waits[p] = 0; hold_v[p] = 1'b0;
    end
    hold_d = 32'd0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 3) != 0) begin
            pend[p]  = 1'b1;
            waits[p] = 0;
            set_port(p, 1'b1, 4'($urandom_range(0, 15)), $urandom,
                     ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom);
          end else begin
            set_port(p, 1'b0, drv_sel[p], drv_a[p], drv_b[p]);
          end
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      #4;
      checks++;
      if (rsp_valid === 2'b11 || req_ready === 2'b11 || (req_ready & ~req_valid) !== 2'b00) begin
        failures++;
        $display("[TB] FAIL rand_handshake%0d: got rsp_valid=%b req_ready=%b req_valid=%b expected one-hot grant within valid",
                 cyc, rsp_valid, req_ready, req_valid);
      end
      for (int p = 0; p < 2; p++) begin
        if (hold_v[p]) begin
          checks++;
          if (!rsp_valid[p] || rsp_data !== hold_d) begin
            failures++;
            $display("[TB] FAIL rand_stable%0d: got valid=%b data=%h expected port %0d data=%h",
                     cyc, rsp_valid, rsp_data, p, hold_d);
          end
        end
        if (rsp_valid[p] && rsp_ready[p]) begin
          e = pop_exp(p);
          checks++;
          if (rsp_data !== e) begin
            failures++;
            $display("[TB] FAIL rand_data%0d: port %0d got %h expected %h", cyc, p, rsp_data, e);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        hold_v[p] = rsp_valid[p] && !rsp_ready[p];
      end
      hold_d = rsp_data;
      sb_push_accepts();
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          pend[p] = 1'b0;
          q = 1 - p;
          if (pend[q]) begin
            waits[q]++;
            checks++;
            if (waits[q] > 1) begin
              failures++;
              $display("[TB] FAIL rand_fairness%0d: port %0d got %0d grants ahead expected at most 1",
                       cyc, q, waits[q]);
            end
          end
        end
      end
    end
    // Drain outstanding responses
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_port(0, 1'b0, drv_sel[0], drv_a[0], drv_b[0]);
      set_port(1, 1'b0, drv_sel[1], drv_a[1], drv_b[1]);
      rsp_ready = 2'b11;
      #4;
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p]) begin
          e = pop_exp(p);
          checks++;
          if (rsp_data !== e) begin
            failures++;
            $display("[TB] FAIL rand_drain: port %0d got %h expected %h", p, rsp_data, e);
          end
        end
      end
    end
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("[TB] FAIL rand_leftover: got %0d/%0d pending expected 0/0",
               exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    set_port(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    set_port(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
